matrix_operand_loader: RTL and testbench
========================================

# matrix_operand_loader

Upstream feeder for the large matrix multiplier. It fetches two MATRIX_WIDTH x MATRIX_WIDTH operand matrices, A and B, from a single-port element memory with 1-cycle read latency. It packs the elements into NUM_ELEMENTS-wide words in the column-major, two-rows-at-a-time order the multiplier's load port consumes. It presents each word on `rdata` with a one-cycle `read_en` strobe.

## Interface
- WIDTH, 8, bits per matrix element
- NUM_ELEMENTS, 4, elements per packed word; fixed at 4 (2 from A, 2 from B)
- MATRIX_WIDTH, 4, matrix dimension N; must be even
- ADDR_WIDTH, 8, memory address width

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a load; sampled only in IDLE
- base_a  in  ADDR_WIDTH  word address of A[0][0]
- base_b  in  ADDR_WIDTH  word address of B[0][0]
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_rdata  in  WIDTH  read data, valid the cycle after `mem_rd`
- rdata  out  NUM_ELEMENTS*WIDTH  packed operand word to the multiplier
- read_en  out  1  one-cycle strobe: `rdata` valid
- busy  out  1  high from the cycle after `start` is accepted through the final `read_en`
- done  out  1  one-cycle pulse, coincident with the final `read_en`

## Operation
- Row-major memory layout: element (r,c) is at base + r*MATRIX_WIDTH + c, computed modulo 2^ADDR_WIDTH. Wrap-around is legal and is not flagged.
- Word order: outer loop c = 0..N-1; inner loop r = 0,2,..,N-2. Total N*N/2 words (8 for N=4).
- Packing: `rdata`[4W-1:3W]=A[r][c], [3W-1:2W]=A[r+1][c], [2W-1:W]=B[r][c], [W-1:0]=B[r+1][c].
- Per word, four reads are issued on consecutive cycles in this order: A[r][c], A[r+1][c], B[r][c], B[r+1][c]. Returned data is shifted into an assembly register.
- Reads are issued back-to-back with no bubbles across word boundaries. Assembly of word w+1 overlaps the output of word w.
- FSM:
  - IDLE: `busy`=0; `start`=1 captures `base_a`/`base_b` and moves to FETCH.
  - FETCH: issues reads, advancing element counter 0..3, then r, then c. After the last address it moves to DRAIN.
  - DRAIN: waits for the final data return and output strobe, then returns to IDLE.
- `start` while busy is ignored. Base inputs may change after acceptance with no effect.
- `rdata` holds the last packed word between strobes.

## Timing
- Reset values: `mem_rd`=0, `mem_addr`=0, `rdata`=0, `read_en`=0, `busy`=0, `done`=0, FSM=IDLE, all counters 0.
- Cycle numbering: `start` is high in cycle 0.
  - First `mem_rd` is in cycle 1.
  - Read for element e of word w is in cycle 1+4w+e.
  - Data returns in cycle 2+4w+e.
  - `read_en` and the new `rdata` are registered in cycle 6+4w.
- N=4: `read_en` is high in cycles 6,10,..,34. `done` is high in cycle 34. `busy` is high in cycles 1..34. `mem_rd` is high in cycles 1..32 continuously.
- Back-to-back loads: `start` asserted in the cycle `busy` falls (cycle 35) is accepted; the next `mem_rd` is in cycle 36.
- Reset mid-operation: all outputs return to reset values on the next cycle. In-flight read data is discarded, and no `read_en` or `done` is produced for the aborted load.
- Reset and `start` high together: reset wins.

## Configuration
- MATRIX_OPERAND_LOADER_CYCLE_CNT_EN, when defined, adds output `cycle_cnt` (32 bits).
  - Clears to 0 when `start` is accepted.
  - Increments every cycle while `busy`=1.
  - Holds its value in IDLE and resets to 0.
  - For N=4 it reads 34 after `done`.
- When the macro is undefined, the port and counter are absent and all other behaviour is identical.

## Test plan
- Memory[k]=k, base_a=0x00, base_b=0x10, start pulse:
  - 8 `read_en` pulses in cycles 6,10,..,34.
  - First `rdata`=0x00_04_10_14; second=0x08_0C_18_1C; third=0x01_05_11_15.
  - `done` coincides with the 8th pulse.
- base_a=0xFC with ADDR_WIDTH=8: A addresses wrap (A[1][0] read from 0x00). Data is packed correctly and no error is raised.
- `start` re-pulsed in cycles 5 and 20 of an active load: ignored, exactly 8 `read_en` pulses. `start` in cycle 35: second load, first `mem_rd` in cycle 36.
- Reset asserted in cycle 12: from cycle 13 all outputs are 0 and no further `read_en`. A new `start` then produces a full, correct 8-word sequence.
- Random memory contents, N=4 and N=8: the bench reconstructs A and B from captured `rdata` words and matches the memory model exactly. The N=8 run gives 32 words with `done` in cycle 130.
- With MATRIX_OPERAND_LOADER_CYCLE_CNT_EN: `cycle_cnt`=34 after a N=4 load; it clears on the next accepted `start`.

Source files
------------

// File: rtl/matrix_operand_loader_if.sv
// rtl/matrix_operand_loader_if.sv - memory read port and packed operand output of the operand loader
//
// Ports grouped here:
//   mem_rd     loader -> memory  read strobe
//   mem_addr   loader -> memory  read address
//   mem_rdata  memory -> loader  read data, valid the cycle after mem_rd
//   rdata      loader -> mult    packed operand word
//   read_en    loader -> mult    one-cycle strobe, rdata valid
// Modports: master = loader side, slave = memory/multiplier side.
interface matrix_operand_loader_if #(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEMENTS = 4,
  parameter int ADDR_WIDTH   = 8
);
  logic                          mem_rd;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [WIDTH-1:0]              mem_rdata;
  logic [NUM_ELEMENTS*WIDTH-1:0] rdata;
  logic                          read_en;

  modport master (
    output mem_rd, mem_addr, rdata, read_en,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd, mem_addr, rdata, read_en,
    output mem_rdata
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// rtl/matrix_operand_loader.sv - fetches matrices A and B and packs them for the multiplier load port
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   start      begin a load (sampled only when idle)
//   base_a     word address of A[0][0]
//   base_b     word address of B[0][0]
//   bus        matrix_operand_loader_if.master (mem_rd/mem_addr/mem_rdata, rdata/read_en)
//   busy       high from the cycle after start is accepted through the final read_en
//   done       one-cycle pulse with the final read_en
//   cycle_cnt  busy-cycle counter, present only with MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
//
// Optional feature macro: MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
module matrix_operand_loader #(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEMENTS = 4,
  parameter int MATRIX_WIDTH = 4,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  matrix_operand_loader_if.master bus,
  output logic                  busy,
  output logic                  done
`ifdef MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
  ,
  output logic [31:0]           cycle_cnt
`endif
);

  localparam int N     = MATRIX_WIDTH;
  localparam int CW    = (N > 2) ? $clog2(N) : 1;
  localparam int WORDS = N * N / 2;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int AW    = (NUM_ELEMENTS - 1) * WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state;
  logic [1:0]            elem;       // next element to issue: 0=A[r] 1=A[r+1] 2=B[r] 3=B[r+1]
  logic [CW-1:0]         row;        // even row of the next read pair
  logic [CW-1:0]         col;
  logic [ADDR_WIDTH-1:0] base_a_q;
  logic [ADDR_WIDTH-1:0] base_b_q;
  logic                  rd_q;       // mem_rdata is valid this cycle
  logic [1:0]            ret_elem;   // element index of the returning data
  logic [AW-1:0]         asm_q;      // first three elements of the word being assembled
  logic [WCW-1:0]        word_cnt;

  logic [ADDR_WIDTH-1:0] sel_base;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  last_elem;

  // Element (r,c) lives at base + r*N + c; the sum wraps at 2^ADDR_WIDTH by truncation.
  always_comb begin
    sel_base  = elem[1] ? base_b_q : base_a_q;
    next_addr = sel_base
              + ADDR_WIDTH'((32'(row) + 32'(elem[0])) * 32'(N))
              + ADDR_WIDTH'(col);
    last_elem = (elem == 2'd3) && (row == CW'(N - 2)) && (col == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      elem         <= '0;
      row          <= '0;
      col          <= '0;
      base_a_q     <= '0;
      base_b_q     <= '0;
      rd_q         <= 1'b0;
      ret_elem     <= '0;
      asm_q        <= '0;
      word_cnt     <= '0;
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
      bus.rdata    <= '0;
      bus.read_en  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
      cycle_cnt    <= '0;
`endif
    end else begin
      bus.read_en <= 1'b0;
      done        <= 1'b0;
      rd_q        <= bus.mem_rd;

      // Return path runs independently of the issue FSM so that assembly of
      // word w+1 overlaps presentation of word w.
      if (rd_q) begin
        ret_elem <= ret_elem + 2'd1;
        asm_q    <= {asm_q[AW-WIDTH-1:0], bus.mem_rdata};
        if (ret_elem == 2'd3) begin
          bus.rdata   <= {asm_q, bus.mem_rdata};
          bus.read_en <= 1'b1;
          word_cnt    <= word_cnt + WCW'(1);
          if (word_cnt == WCW'(WORDS - 1)) done <= 1'b1;
        end
      end

`ifdef MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
      if (busy) cycle_cnt <= cycle_cnt + 32'd1;
`endif

      case (state)
        IDLE: begin
          if (start) begin
            base_a_q     <= base_a;
            base_b_q     <= base_b;
            // A[0][0] is issued straight from the input so the first read lands in cycle 1.
            bus.mem_addr <= base_a;
            bus.mem_rd   <= 1'b1;
            elem         <= 2'd1;
            row          <= '0;
            col          <= '0;
            ret_elem     <= '0;
            word_cnt     <= '0;
            busy         <= 1'b1;
            state        <= FETCH;
`ifdef MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
            cycle_cnt    <= '0;
`endif
          end
        end
        FETCH: begin
          bus.mem_rd   <= 1'b1;
          bus.mem_addr <= next_addr;
          elem         <= elem + 2'd1;
          if (elem == 2'd3) begin
            if (row == CW'(N - 2)) begin
              row <= '0;
              col <= col + CW'(1);
            end else begin
              row <= row + CW'(2);
            end
          end
          if (last_elem) state <= DRAIN;
        end
        DRAIN: begin
          bus.mem_rd <= 1'b0;
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// tb/tb_matrix_operand_loader.sv - self-checking bench for matrix_operand_loader (N=4 and N=8 instances)
module tb_matrix_operand_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start4, start8;
  logic [7:0] ba4, bb4, ba8, bb8;
  logic       busy4, done4, busy8, done8;
`ifdef MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
  logic [31:0] cnt4, cnt8;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [256];
  logic [31:0] exp_q[$];
  int          exp_cyc[$];
  logic [31:0] got_words[3];

  always #5 clk = ~clk;

  matrix_operand_loader_if #(.WIDTH(8), .NUM_ELEMENTS(4), .ADDR_WIDTH(8)) bus4 ();
  matrix_operand_loader_if #(.WIDTH(8), .NUM_ELEMENTS(4), .ADDR_WIDTH(8)) bus8 ();

  matrix_operand_loader #(.WIDTH(8), .NUM_ELEMENTS(4), .MATRIX_WIDTH(4), .ADDR_WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .base_a(ba4), .base_b(bb4),
    .bus(bus4), .busy(busy4), .done(done4)
`ifdef MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
    , .cycle_cnt(cnt4)
`endif
  );

  matrix_operand_loader #(.WIDTH(8), .NUM_ELEMENTS(4), .MATRIX_WIDTH(8), .ADDR_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .base_a(ba8), .base_b(bb8),
    .bus(bus8), .busy(busy8), .done(done8)
`ifdef MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
    , .cycle_cnt(cnt8)
`endif
  );

  // Memory model, 1-cycle read latency.
  always @(posedge clk) begin
    if (bus4.mem_rd) bus4.mem_rdata <= mem[bus4.mem_addr];
    if (bus8.mem_rd) bus8.mem_rdata <= mem[bus8.mem_addr];
  end

  int          sel = 4;
  logic        s_rd, s_ren, s_busy, s_done;
  logic [7:0]  s_addr;
  logic [31:0] s_rdata;

  always_comb begin
    if (sel == 4) begin
      s_rd = bus4.mem_rd; s_addr = bus4.mem_addr; s_rdata = bus4.rdata;
      s_ren = bus4.read_en; s_busy = busy4; s_done = done4;
    end else begin
      s_rd = bus8.mem_rd; s_addr = bus8.mem_addr; s_rdata = bus8.rdata;
      s_ren = bus8.read_en; s_busy = busy8; s_done = done8;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] b);
    if (sel == 4) begin start4 = st; ba4 = a; bb4 = b; end
    else          begin start8 = st; ba8 = a; bb8 = b; end
  endtask

  // Call mid-cycle; that cycle becomes cycle 0 of the load. Returns mid-cycle last+1.
  task automatic run_load(input int sel_i, input logic [7:0] ba, input logic [7:0] bb,
                          input int n, input int re1, input int re2, input int abort_at);
    int          words = n * n / 2;
    int          last  = 6 + 4 * (words - 1);
    int          w     = 0;
    int          ncap  = 0;
    int          nren;
    logic [31:0] word, last_word;
    logic [7:0]  a0, a1, b0, b1;
    sel = sel_i;
    for (int c = 0; c < n; c++) begin
      for (int r = 0; r < n; r += 2) begin
        a0 = ba + 8'(r * n + c);       a1 = ba + 8'((r + 1) * n + c);
        b0 = bb + 8'(r * n + c);       b1 = bb + 8'((r + 1) * n + c);
        word = {mem[a0], mem[a1], mem[b0], mem[b1]};
        exp_q.push_back(word);
        exp_cyc.push_back(6 + 4 * w);
        w++;
      end
    end
    last_word = exp_q[exp_q.size() - 1];
    drive(1'b1, ba, bb);
    for (int cyc = 1; cyc <= last + 1; cyc++) begin
      @(negedge clk);
      // Scrambled bases after acceptance must have no effect.
      drive((cyc == re1) || (cyc == re2), ~ba, ~bb);
      if (abort_at >= 0 && cyc == abort_at) reset = 1'b1;
      if (abort_at >= 0 && cyc == abort_at + 1) begin
        reset = 1'b0;
        check("abort_outputs_zero", {s_rd, s_addr, s_rdata, s_ren, s_busy, s_done}, 64'd0);
        exp_q.delete();
        exp_cyc.delete();
        nren = 0;
        for (int k = 0; k < 30; k++) begin
          @(negedge clk);
          if (s_ren) nren++;
        end
        check("abort_no_read_en", nren, 0);
        return;
      end
`ifdef MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
      if (cyc == 1 && sel == 4) check("cycle_cnt_cleared", cnt4, 0);
`endif
      if (s_ren) begin
        if (exp_q.size() == 0) begin
          check("extra_read_en", 1, 0);
        end else begin
          word = exp_q.pop_front();
          check("rdata_word", s_rdata, word);
          check("read_en_cycle", cyc, exp_cyc.pop_front());
          if (ncap < 3) got_words[ncap] = s_rdata;
          ncap++;
        end
      end
      check("ctrl_busy_rd_done", {s_busy, s_rd, s_done},
            {cyc <= last, cyc <= 4 * words, cyc == last});
    end
    check("words_missing", exp_q.size(), 0);
    check("rdata_hold", s_rdata, last_word);
    exp_q.delete();
    exp_cyc.delete();
  endtask

  initial begin
    reset = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    ba4 = '0; bb4 = '0; ba8 = '0; bb8 = '0;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    repeat (3) @(negedge clk);
    check("reset_state_n4", {bus4.mem_rd, bus4.mem_addr, bus4.rdata, bus4.read_en, busy4, done4}, 64'd0);
    check("reset_state_n8", {bus8.mem_rd, bus8.mem_addr, bus8.rdata, bus8.read_en, busy8, done8}, 64'd0);
`ifdef MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
    check("reset_cycle_cnt", cnt4, 0);
`endif
    // Reset and start together: reset wins.
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check("reset_beats_start", {bus4.mem_rd, busy4}, 2'b00);

    // Identity memory, base_a=0x00, base_b=0x10.
    run_load(4, 8'h00, 8'h10, 4, -1, -1, -1);
    check("first_word", got_words[0], 32'h00041014);
    check("second_word", got_words[1], 32'h080C181C);
    check("third_word", got_words[2], 32'h01051115);

    // A wraps past 0xFF.
    run_load(4, 8'hFC, 8'h10, 4, -1, -1, -1);
    check("wrap_first_word", got_words[0], 32'hFC001014);

    // Start re-pulsed while busy, then a back-to-back load.
    run_load(4, 8'h00, 8'h10, 4, 5, 20, -1);
`ifdef MATRIX_OPERAND_LOADER_CYCLE_CNT_EN
    check("cycle_cnt_after_load", cnt4, 34);
`endif
    run_load(4, 8'h20, 8'h30, 4, -1, -1, -1);

    // Reset in cycle 12, then a fresh full load.
    run_load(4, 8'h00, 8'h10, 4, -1, -1, 12);
    run_load(4, 8'h00, 8'h10, 4, -1, -1, -1);

    // Random contents, N=4 and N=8.
    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom_range(0, 255));
    run_load(4, 8'h40, 8'h80, 4, -1, -1, -1);
    run_load(8, 8'h00, 8'h40, 8, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
